mpf_svc_vtp_l2_client_arb: RTL and testbench
============================================

Name: mpf_svc_vtp_l2_client_arb

Overview:
Service-side responder for the L1-miss path of the VTP translation ports. It collects translation-miss requests from N_PORTS private L1 clients and round-robin arbitrates them into the single shared L2 lookup/page-walk engine. It routes the engine's out-of-order, tagged responses back to the originating client. It enforces a per-client outstanding limit and keeps lookup/error statistics for CSRs.

Parameters:
N_PORTS, 4, number of L1 client ports (1..16)
VA_IDX_W, 36, 4KB virtual page index width
PA_IDX_W, 36, 4KB physical page index width
MAX_OUTSTANDING, 4, max in-flight lookups per client (1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cli_reqEn  in  N_PORTS  per-client miss request strobe
cli_reqVA  in  N_PORTS*VA_IDX_W  per-client VA page index
cli_notFull  out  N_PORTS  client may assert reqEn this cycle
cli_rspValid  out  N_PORTS  one-hot response strobe
cli_rspPA  out  PA_IDX_W  shared response PA page index
cli_rspIsBigPage  out  1  shared: translation is a 2MB page
cli_rspError  out  1  shared: translation failed
svc_reqEn  out  1  request to L2 engine valid
svc_reqRdy  in  1  L2 engine accepts request
svc_reqVA  out  VA_IDX_W  request VA page index
svc_reqTag  out  $clog2(N_PORTS) max 1  originating client index
svc_rspValid  in  1  L2 engine response valid (always accepted)
svc_rspTag  in  same as svc_reqTag  response client index
svc_rspPA  in  PA_IDX_W  response PA page index
svc_rspIsBigPage  in  1  2MB page flag
svc_rspError  in  1  translation failure
stat_lookups  out  32  count of issued lookups, wraps
stat_errors  out  32  count of error responses delivered, wraps
err_unexpected_rsp  out  1  sticky protocol-violation flag

Behaviour:
- Reset: all slots invalid, all outstanding counters 0, rr_ptr=0, cli_notFull all 1 in the first cycle after reset. cli_rspValid=0, svc_reqEn=0, stats=0, err_unexpected_rsp=0. Outputs are driven to these values while reset is held.
- Per-client one-entry input slot (slot_valid[i], slot_va[i]). cli_notFull[i] = !slot_valid[i], driven directly from the flop.
- Input capture: cli_reqEn[i] && cli_notFull[i] at edge t loads the slot; slot_valid is 1 from t+1. reqEn while notFull=0 is dropped and flagged by a simulation assertion.
- Eligibility: eligible[i] = slot_valid[i] && outstanding[i] < MAX_OUTSTANDING.
- Arbitration:
  - svc_reqEn = any eligible, combinational from flops only; no dependence on svc_reqRdy.
  - Grant = first eligible index scanning from rr_ptr upward, modulo N_PORTS. svc_reqVA and svc_reqTag come from the granted slot.
  - svc_reqEn and payload hold stable until svc_reqRdy is seen. If eligibility changes, a re-grant is permitted before acceptance.
- Issue: svc_reqEn && svc_reqRdy.
  - Clears slot_valid[grant] and increments outstanding[grant].
  - Sets rr_ptr <= (grant+1) mod N_PORTS and increments stat_lookups.
  - The freed slot shows notFull=1 next cycle, so the minimum per-client request spacing is 2 cycles.
- Response: svc_rspValid with a valid tag (tag < N_PORTS and outstanding[tag] > 0):
  - Next cycle: cli_rspValid = one-hot(tag), shared data bus = registered svc_rsp fields.
  - outstanding[tag] decrements; stat_errors increments if svc_rspError.
  - Fixed latency is 1 cycle. Clients cannot backpressure and must sink every response.
- Same cycle issue and response for the same client: outstanding is unchanged (net zero), and the limit check uses the pre-update value.
- Unexpected response (tag >= N_PORTS or outstanding[tag]==0): dropped with no cli_rspValid, err_unexpected_rsp sets and stays set until reset.
- MAX_OUTSTANDING reached: the client's slot stays valid and is skipped by arbitration. cli_notFull stays 0 until the slot issues.
- Responses may return in any order across and within clients. The block does not reorder; per-client VA-to-response matching is the client's responsibility.
- Reset mid-operation clears all state. The L2 engine is reset with this block, and any stray post-reset response is treated as unexpected.
- Counters use modulo 2^32 arithmetic; outstanding counters are $clog2(MAX_OUTSTANDING+1) bits.

Test Plan:
- Single lookup: client 2 reqVA=0x123 with svc_reqRdy=1 -> svc_reqEn next cycle, VA=0x123, tag=2. Engine responds PA=0x456 -> cli_rspValid=4'b0100, PA=0x456 one cycle later, stat_lookups=1.
- Round robin: all 4 clients load slots simultaneously, svc_reqRdy=1 -> issue order tags 0,1,2,3 on consecutive cycles, rr_ptr=0 after the 4th issue.
- Backpressure: svc_reqRdy=0 for 5 cycles with client 1 pending -> svc_reqEn=1, tag=1, VA stable all 5 cycles. cli_notFull[1]=0 throughout; issue on the first svc_reqRdy=1 cycle.
- Outstanding limit: client 0 issues 4 lookups with no responses, 5th request loaded -> svc_reqEn=0. One response for tag 0 arrives -> 5th issues the next cycle.
- Out-of-order plus error: issue tags 0 then 3, respond tag 3 (error=1) before tag 0 -> cli_rspValid=4'b1000 with rspError=1, then 4'b0001, stat_errors=1.
- Unexpected response: svc_rspValid with tag=1 while outstanding[1]=0 -> no cli_rspValid, err_unexpected_rsp=1 and held. Assert reset -> flag clears, notFull=4'b1111.

Source files
------------

// File: rtl/mpf_svc_vtp_l2_client_arb.sv
// Round-robin funnel from N private L1 miss ports into one shared L2 walker, with tag-routed responses.
// Request: slot to svc_reqEn in 1 cycle, held until svc_reqRdy; response: 1 cycle, no client backpressure.
module mpf_svc_vtp_l2_client_arb #(
    parameter int N_PORTS         = 4,
    parameter int VA_IDX_W        = 36,
    parameter int PA_IDX_W        = 36,
    parameter int MAX_OUTSTANDING = 4,
    localparam int TAG_W          = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
    localparam int OCNT_W         = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic [N_PORTS-1:0]            cli_reqEn,
    input  logic [N_PORTS*VA_IDX_W-1:0]   cli_reqVA,
    output logic [N_PORTS-1:0]            cli_notFull,
    output logic [N_PORTS-1:0]            cli_rspValid,
    output logic [PA_IDX_W-1:0]           cli_rspPA,
    output logic                          cli_rspIsBigPage,
    output logic                          cli_rspError,

    output logic                          svc_reqEn,
    input  logic                          svc_reqRdy,
    output logic [VA_IDX_W-1:0]           svc_reqVA,
    output logic [TAG_W-1:0]              svc_reqTag,
    input  logic                          svc_rspValid,
    input  logic [TAG_W-1:0]              svc_rspTag,
    input  logic [PA_IDX_W-1:0]           svc_rspPA,
    input  logic                          svc_rspIsBigPage,
    input  logic                          svc_rspError,

    output logic [31:0]                   stat_lookups,
    output logic [31:0]                   stat_errors,
    output logic                          err_unexpected_rsp
);

    logic [N_PORTS-1:0]    slotValid;
    logic [VA_IDX_W-1:0]   slotVA      [N_PORTS];
    logic [OCNT_W-1:0]     outstanding [N_PORTS];
    logic [TAG_W-1:0]      rrPtr;

    logic [N_PORTS-1:0]    eligible;
    logic [2*N_PORTS-1:0]  rotElig;
    logic [TAG_W:0]        cand;
    logic                  found;
    logic [TAG_W-1:0]      grant;
    logic                  issue;
    logic                  rspTagInRange;
    logic                  rspExpected;

    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            eligible[i] = slotValid[i] && (outstanding[i] < OCNT_W'(MAX_OUTSTANDING));
        end
    end

    // Rotate so bit k of rotElig is client (rrPtr+k) mod N; first set bit wins.
    always_comb begin
        rotElig = {eligible, eligible} >> rrPtr;
        grant   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = {1'b0, rrPtr} + (TAG_W+1)'(k);
            if (cand >= (TAG_W+1)'(N_PORTS)) begin
                cand = cand - (TAG_W+1)'(N_PORTS);
            end
            if (!found && rotElig[k]) begin
                grant = cand[TAG_W-1:0];
                found = 1'b1;
            end
        end
    end

    assign svc_reqEn   = |eligible;
    assign svc_reqTag  = grant;
    assign svc_reqVA   = slotVA[grant];
    assign cli_notFull = ~slotValid;
    assign issue       = svc_reqEn && svc_reqRdy;

    // Responses are only trusted when the tag names a client with a lookup in flight.
    assign rspTagInRange = ({1'b0, svc_rspTag} < (TAG_W+1)'(N_PORTS));
    assign rspExpected   = svc_rspValid && rspTagInRange && (outstanding[svc_rspTag] != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            slotValid          <= '0;
            rrPtr              <= '0;
            cli_rspValid       <= '0;
            stat_lookups       <= '0;
            stat_errors        <= '0;
            err_unexpected_rsp <= 1'b0;
            for (int i = 0; i < N_PORTS; i++) begin
                outstanding[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (issue && (grant == TAG_W'(i))) begin
                    slotValid[i] <= 1'b0;
                end else if (cli_reqEn[i] && !slotValid[i]) begin
                    slotValid[i] <= 1'b1;
                end

                // Issue and response to the same client in one cycle cancel out.
                case ({issue && (grant == TAG_W'(i)), rspExpected && (svc_rspTag == TAG_W'(i))})
                    2'b10:   outstanding[i] <= outstanding[i] + OCNT_W'(1);
                    2'b01:   outstanding[i] <= outstanding[i] - OCNT_W'(1);
                    default: outstanding[i] <= outstanding[i];
                endcase
            end

            if (issue) begin
                stat_lookups <= stat_lookups + 32'd1;
                if (grant == TAG_W'(N_PORTS - 1)) begin
                    rrPtr <= '0;
                end else begin
                    rrPtr <= grant + TAG_W'(1);
                end
            end

            if (rspExpected) begin
                cli_rspValid <= N_PORTS'(1) << svc_rspTag;
                if (svc_rspError) begin
                    stat_errors <= stat_errors + 32'd1;
                end
            end else begin
                cli_rspValid <= '0;
            end

            if (svc_rspValid && !rspExpected) begin
                err_unexpected_rsp <= 1'b1;
            end
        end
    end

    // Payload registers carry no reset; they are qualified by slotValid / cli_rspValid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_PORTS; i++) begin
            if (cli_reqEn[i] && !slotValid[i]) begin
                slotVA[i] <= cli_reqVA[i*VA_IDX_W +: VA_IDX_W];
            end
        end
        if (rspExpected) begin
            cli_rspPA        <= svc_rspPA;
            cli_rspIsBigPage <= svc_rspIsBigPage;
            cli_rspError     <= svc_rspError;
        end
    end

    reqWhileFull: assert property (@(posedge clk) disable iff (reset)
                                   ((cli_reqEn & slotValid) == '0));

endmodule

// File: tb/tb_mpf_svc_vtp_l2_client_arb.sv
// Directed vector bench for the L1-miss client arbiter: per-cycle stimulus with hand-computed expectations.
module tb_mpf_svc_vtp_l2_client_arb;

    localparam int NP   = 4;
    localparam int VA_W = 36;
    localparam int PA_W = 36;

    logic              clk;
    logic              reset;
    logic [NP-1:0]     cli_reqEn;
    logic [NP*VA_W-1:0] cli_reqVA;
    logic [NP-1:0]     cli_notFull;
    logic [NP-1:0]     cli_rspValid;
    logic [PA_W-1:0]   cli_rspPA;
    logic              cli_rspIsBigPage;
    logic              cli_rspError;
    logic              svc_reqEn;
    logic              svc_reqRdy;
    logic [VA_W-1:0]   svc_reqVA;
    logic [1:0]        svc_reqTag;
    logic              svc_rspValid;
    logic [1:0]        svc_rspTag;
    logic [PA_W-1:0]   svc_rspPA;
    logic              svc_rspIsBigPage;
    logic              svc_rspError;
    logic [31:0]       stat_lookups;
    logic [31:0]       stat_errors;
    logic              err_unexpected_rsp;

    mpf_svc_vtp_l2_client_arb #(
        .N_PORTS(NP), .VA_IDX_W(VA_W), .PA_IDX_W(PA_W), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .reset(reset),
        .cli_reqEn(cli_reqEn), .cli_reqVA(cli_reqVA), .cli_notFull(cli_notFull),
        .cli_rspValid(cli_rspValid), .cli_rspPA(cli_rspPA),
        .cli_rspIsBigPage(cli_rspIsBigPage), .cli_rspError(cli_rspError),
        .svc_reqEn(svc_reqEn), .svc_reqRdy(svc_reqRdy), .svc_reqVA(svc_reqVA),
        .svc_reqTag(svc_reqTag), .svc_rspValid(svc_rspValid), .svc_rspTag(svc_rspTag),
        .svc_rspPA(svc_rspPA), .svc_rspIsBigPage(svc_rspIsBigPage), .svc_rspError(svc_rspError),
        .stat_lookups(stat_lookups), .stat_errors(stat_errors),
        .err_unexpected_rsp(err_unexpected_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  reqEn;
        logic [35:0] base;     // client i drives VA = base + i
        logic        rdy;
        logic        rspV;
        logic [1:0]  tag;
        logic [35:0] pa;       // response big-page flag is driven as pa[0]
        logic        err;
        logic [3:0]  eNF;
        logic        eRE;
        logic [1:0]  eTag;
        logic [35:0] eVA;
        logic [3:0]  eRV;
        logic [35:0] ePA;
        logic        eErr;
        logic [31:0] eL;
        logic [31:0] eE;
        logic        eU;
    } vec_t;

    vec_t vecs[$];
    int   nVec = 0;
    int   nMiss = 0;

    task automatic v(input logic rst, input logic [3:0] reqEn, input logic [35:0] base,
                     input logic rdy, input logic rspV, input logic [1:0] tag,
                     input logic [35:0] pa, input logic err,
                     input logic [3:0] eNF, input logic eRE, input logic [1:0] eTag,
                     input logic [35:0] eVA, input logic [3:0] eRV, input logic [35:0] ePA,
                     input logic eErr, input logic [31:0] eL, input logic [31:0] eE,
                     input logic eU);
        vec_t t;
        t.rst = rst; t.reqEn = reqEn; t.base = base; t.rdy = rdy; t.rspV = rspV;
        t.tag = tag; t.pa = pa; t.err = err; t.eNF = eNF; t.eRE = eRE; t.eTag = eTag;
        t.eVA = eVA; t.eRV = eRV; t.ePA = ePA; t.eErr = eErr; t.eL = eL; t.eE = eE;
        t.eU = eU;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        if (act !== exp) begin
            $display("FAIL vec %0d %s: actual 0x%0h required 0x%0h", idx, name, act, exp);
            nMiss++;
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        reset        = t.rst;
        cli_reqEn    = t.reqEn;
        for (int i = 0; i < NP; i++) cli_reqVA[i*VA_W +: VA_W] = t.base + 36'(i);
        svc_reqRdy   = t.rdy;
        svc_rspValid = t.rspV;
        svc_rspTag   = t.tag;
        svc_rspPA    = t.pa;
        svc_rspIsBigPage = t.pa[0];
        svc_rspError = t.err;
        @(negedge clk);
        nVec++;
        chk("notFull", idx, 64'(cli_notFull), 64'(t.eNF));
        chk("svc_reqEn", idx, 64'(svc_reqEn), 64'(t.eRE));
        if (t.eRE) begin
            chk("svc_reqTag", idx, 64'(svc_reqTag), 64'(t.eTag));
            chk("svc_reqVA", idx, 64'(svc_reqVA), 64'(t.eVA));
        end
        chk("cli_rspValid", idx, 64'(cli_rspValid), 64'(t.eRV));
        if (t.eRV != 4'd0) begin
            chk("cli_rspPA", idx, 64'(cli_rspPA), 64'(t.ePA));
            chk("cli_rspIsBigPage", idx, 64'(cli_rspIsBigPage), 64'(t.ePA[0]));
            chk("cli_rspError", idx, 64'(cli_rspError), 64'(t.eErr));
        end
        chk("stat_lookups", idx, 64'(stat_lookups), 64'(t.eL));
        chk("stat_errors", idx, 64'(stat_errors), 64'(t.eE));
        chk("err_unexpected_rsp", idx, 64'(err_unexpected_rsp), 64'(t.eU));
    endtask

    initial begin
        reset = 1'b1; cli_reqEn = '0; cli_reqVA = '0; svc_reqRdy = 1'b0;
        svc_rspValid = 1'b0; svc_rspTag = '0; svc_rspPA = '0;
        svc_rspIsBigPage = 1'b0; svc_rspError = 1'b0;

        // Reset held
        for (int k = 0; k < 3; k++) v(1,0,0,0,0,0,0,0, 4'hF,0,0,0, 0,0,0, 0,0,0);

        // Round robin from rrPtr=0: all four load together, issue 0,1,2,3
        v(0,4'hF,36'h100,1,0,0,0,0, 4'h0,1,0,36'h100, 0,0,0, 0,0,0);
        v(0,0,0,1,0,0,0,0, 4'h1,1,1,36'h101, 0,0,0, 1,0,0);
        v(0,0,0,1,0,0,0,0, 4'h3,1,2,36'h102, 0,0,0, 2,0,0);
        v(0,0,0,1,0,0,0,0, 4'h7,1,3,36'h103, 0,0,0, 3,0,0);
        v(0,0,0,1,0,0,0,0, 4'hF,0,0,0, 0,0,0, 4,0,0);
        for (int k = 0; k < 4; k++)
            v(0,0,0,1,1,2'(k),36'h10 + 36'(k),0, 4'hF,0,0,0, 4'(1 << k),36'h10 + 36'(k),0, 4,0,0);

        // Single lookup, client 2 VA 0x123 -> PA 0x456
        v(0,4'h4,36'h121,1,0,0,0,0, 4'hB,1,2,36'h123, 0,0,0, 4,0,0);
        v(0,0,0,1,0,0,0,0, 4'hF,0,0,0, 0,0,0, 5,0,0);
        v(0,0,0,1,1,2,36'h456,0, 4'hF,0,0,0, 4'h4,36'h456,0, 5,0,0);
        v(0,0,0,1,0,0,0,0, 4'hF,0,0,0, 0,0,0, 5,0,0);

        // Backpressure: client 1 held five cycles with svc_reqRdy low
        v(0,4'h2,36'h200,0,0,0,0,0, 4'hD,1,1,36'h201, 0,0,0, 5,0,0);
        for (int k = 0; k < 5; k++) v(0,0,0,0,0,0,0,0, 4'hD,1,1,36'h201, 0,0,0, 5,0,0);
        v(0,0,0,1,0,0,0,0, 4'hF,0,0,0, 0,0,0, 6,0,0);
        v(0,0,0,1,1,1,36'h21,0, 4'hF,0,0,0, 4'h2,36'h21,0, 6,0,0);

        // Outstanding limit on client 0
        for (int k = 0; k < 4; k++) begin
            v(0,4'h1,36'h300 + 36'(k),1,0,0,0,0, 4'hE,1,0,36'h300 + 36'(k), 0,0,0, 32'(6+k),0,0);
            v(0,0,0,1,0,0,0,0, 4'hF,0,0,0, 0,0,0, 32'(7+k),0,0);
        end
        v(0,4'h1,36'h304,1,0,0,0,0, 4'hE,0,0,0, 0,0,0, 10,0,0);
        v(0,0,0,1,0,0,0,0, 4'hE,0,0,0, 0,0,0, 10,0,0);
        v(0,0,0,1,1,0,36'h30,0, 4'hE,1,0,36'h304, 4'h1,36'h30,0, 10,0,0);
        v(0,0,0,1,0,0,0,0, 4'hF,0,0,0, 0,0,0, 11,0,0);
        for (int k = 0; k < 4; k++)
            v(0,0,0,1,1,0,36'h31 + 36'(k),0, 4'hF,0,0,0, 4'h1,36'h31 + 36'(k),0, 11,0,0);

        // Out-of-order with error: issue 0 then 3, answer 3 (error) first
        v(0,4'h1,36'h400,1,0,0,0,0, 4'hE,1,0,36'h400, 0,0,0, 11,0,0);
        v(0,4'h8,36'h400,1,0,0,0,0, 4'h7,1,3,36'h403, 0,0,0, 12,0,0);
        v(0,0,0,1,0,0,0,0, 4'hF,0,0,0, 0,0,0, 13,0,0);
        v(0,0,0,1,1,3,36'h43,1, 4'hF,0,0,0, 4'h8,36'h43,1, 13,1,0);
        v(0,0,0,1,1,0,36'h40,0, 4'hF,0,0,0, 4'h1,36'h40,0, 13,1,0);

        // Same-cycle issue and response on client 2 leaves outstanding at 1
        v(0,4'h4,36'h500,1,0,0,0,0, 4'hB,1,2,36'h502, 0,0,0, 13,1,0);
        v(0,0,0,1,0,0,0,0, 4'hF,0,0,0, 0,0,0, 14,1,0);
        v(0,4'h4,36'h510,1,0,0,0,0, 4'hB,1,2,36'h512, 0,0,0, 14,1,0);
        v(0,0,0,1,1,2,36'h55,0, 4'hF,0,0,0, 4'h4,36'h55,0, 15,1,0);
        v(0,0,0,1,1,2,36'h56,0, 4'hF,0,0,0, 4'h4,36'h56,0, 15,1,0);
        // Client 2 now idle: extra response is unexpected and dropped
        v(0,0,0,1,1,2,36'h57,0, 4'hF,0,0,0, 0,0,0, 15,1,1);
        v(0,0,0,1,1,1,36'h58,0, 4'hF,0,0,0, 0,0,0, 15,1,1);
        v(0,0,0,1,0,0,0,0, 4'hF,0,0,0, 0,0,0, 15,1,1);

        // Reset mid-operation with a pending slot
        v(0,4'h2,36'h600,0,0,0,0,0, 4'hD,1,1,36'h601, 0,0,0, 15,1,1);
        v(1,0,0,0,0,0,0,0, 4'hF,0,0,0, 0,0,0, 0,0,0);
        v(1,0,0,0,0,0,0,0, 4'hF,0,0,0, 0,0,0, 0,0,0);
        v(0,0,0,1,0,0,0,0, 4'hF,0,0,0, 0,0,0, 0,0,0);

        @(negedge clk);
        foreach (vecs[i]) apply(vecs[i], i);

        // Stray response right after reset must be flagged, not delivered, and stick
        reset = 1'b0; cli_reqEn = '0; svc_reqRdy = 1'b1;
        svc_rspValid = 1'b1; svc_rspTag = 2'd0; svc_rspPA = 36'h70; svc_rspError = 1'b0;
        @(negedge clk);
        svc_rspValid = 1'b0;
        nVec++;
        chk("stray rspValid", nVec, 64'(cli_rspValid), 64'(0));
        chk("stray flag", nVec, 64'(err_unexpected_rsp), 64'(1));
        chk("stray notFull", nVec, 64'(cli_notFull), 64'(4'hF));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nVec++;
            chk("flag sticky", nVec, 64'(err_unexpected_rsp), 64'(1));
            chk("idle rspValid", nVec, 64'(cli_rspValid), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
